// File: rtl/issue_scheduler_if.sv
// Issue scheduler FIFO-head bundle: empty flags, operand-ready bits and pop strobes
// for the four execution FIFOs (0=INT, 1=MEM, 2=MUL, 3=DIV).
interface issue_scheduler_if;
    logic [3:0] q_empty;
    logic [3:0] q_rs1_valid;
    logic [3:0] q_rs2_valid;
    logic [3:0] q_rd_en;

    modport master (
        input  q_empty,
        input  q_rs1_valid,
        input  q_rs2_valid,
        output q_rd_en
    );

    modport slave (
        output q_empty,
        output q_rs1_valid,
        output q_rs2_valid,
        input  q_rd_en
    );
endinterface

// File: rtl/issue_scheduler.sv
// Single-issue dispatch scheduler. Picks at most one ready FIFO head per cycle in
// round-robin order, and books the CDB cycle its result will occupy in a shift-register
// reservation table so that two units never drive the CDB in the same cycle.
module issue_scheduler #(
    parameter int INT_LAT = 1,
    parameter int MEM_LAT = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                flush,
    input  logic                mem_stall,
    issue_scheduler_if.master   fifo,
    output logic                issue_valid,
    output logic [1:0]          issue_sel,
    output logic                cdb_valid_slot,
    output logic [1:0]          cdb_owner,
    output logic                div_busy
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam int LAT [4] = '{INT_LAT, MEM_LAT, MUL_LAT, DIV_LAT};

    logic [DIV_LAT-1:0] slot_v;
    logic [1:0]         slot_own [DIV_LAT];
    logic [CNT_W-1:0]   div_cnt;
    logic [1:0]         rr_ptr;

    logic [3:0]         slot_free;
    logic [3:0]         unit_ok;
    logic [3:0]         eligible;
    logic [3:0]         rd_en;
    logic               found;
    logic [1:0]         winner;
    logic [DIV_LAT-1:0] claim;

    // A unit may only issue if the CDB cycle its result lands in is still unbooked;
    // the divider has the longest latency so its landing cycle can never be taken yet.
    always_comb begin
        slot_free = 4'b1111;
        for (int u = 0; u < 3; u++) begin
            for (int k = 0; k < DIV_LAT; k++) begin
                if (LAT[u] == k && slot_v[k]) begin
                    slot_free[u] = 1'b0;
                end
            end
        end
    end

    // The divider may start again in the last busy cycle, when the previous quotient
    // is already on the CDB and the unit is handing it off.
    always_comb begin
        unit_ok  = {(div_cnt <= CNT_W'(1)), 1'b1, ~mem_stall, 1'b1};
        eligible = ~fifo.q_empty & fifo.q_rs1_valid & fifo.q_rs2_valid & slot_free & unit_ok;
    end

    // Round-robin search starting at rr_ptr; flush and reset suppress the pop strobe.
    always_comb begin
        logic [1:0] cand;
        found  = 1'b0;
        winner = 2'd0;
        rd_en  = 4'b0000;
        for (int off = 0; off < 4; off++) begin
            cand = rr_ptr + off[1:0];
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        if (found && !flush && i_rst_n) begin
            rd_en[winner] = 1'b1;
        end
    end

    // Decode which reservation entry the issuing unit books (entry L-1, seen as L cycles out).
    always_comb begin
        claim = '0;
        for (int k = 0; k < DIV_LAT; k++) begin
            if (issue_valid && LAT[winner] == k + 1) begin
                claim[k] = 1'b1;
            end
        end
    end

    assign fifo.q_rd_en   = rd_en;
    assign issue_valid    = |rd_en;
    assign issue_sel      = issue_valid ? winner : 2'd0;
    assign cdb_valid_slot = slot_v[0];
    assign cdb_owner      = slot_own[0];
    assign div_busy       = (div_cnt != '0);

    // Advance the reservation table, divider countdown and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_v  <= '0;
            for (int k = 0; k < DIV_LAT; k++) begin
                slot_own[k] <= 2'd0;
            end
            div_cnt <= '0;
            rr_ptr  <= 2'd0;
        end else if (flush) begin
            slot_v  <= '0;
            for (int k = 0; k < DIV_LAT; k++) begin
                slot_own[k] <= 2'd0;
            end
            div_cnt <= '0;
            rr_ptr  <= 2'd0;
        end else begin
            for (int k = 0; k < DIV_LAT - 1; k++) begin
                slot_v[k]   <= claim[k] ? 1'b1   : slot_v[k+1];
                slot_own[k] <= claim[k] ? winner : slot_own[k+1];
            end
            slot_v[DIV_LAT-1]   <= claim[DIV_LAT-1];
            slot_own[DIV_LAT-1] <= claim[DIV_LAT-1] ? winner : 2'd0;
            if (rd_en[3]) begin
                div_cnt <= CNT_W'(DIV_LAT);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - CNT_W'(1);
            end
            if (issue_valid) begin
                rr_ptr <= winner + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler: directed cycle tables for the documented scenarios,
// then randomized traffic compared against a calendar-based reference model.
module tb_issue_scheduler;

    localparam int INT_LAT = 1;
    localparam int MEM_LAT = 2;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    typedef struct {
        int         scen;
        logic       flush;
        logic [3:0] empty;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       stall;
        logic [3:0] expRd;
        logic       expCdb;
        logic [1:0] expOwner;
        logic       expBusy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       mem_stall = 1'b0;
    logic       issue_valid;
    logic [1:0] issue_sel;
    logic       cdb_valid_slot;
    logic [1:0] cdb_owner;
    logic       div_busy;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    int mClaim[int];
    int mCyc;
    int mRr;
    int mDivLast;

    issue_scheduler_if qif ();

    issue_scheduler #(
        .INT_LAT (INT_LAT),
        .MEM_LAT (MEM_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .flush          (flush),
        .mem_stall      (mem_stall),
        .fifo           (qif.master),
        .issue_valid    (issue_valid),
        .issue_sel      (issue_sel),
        .cdb_valid_slot (cdb_valid_slot),
        .cdb_owner      (cdb_owner),
        .div_busy       (div_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    function automatic vec_t mk(int scen, logic fl, logic [3:0] emp, logic [3:0] r1, logic [3:0] r2,
                                logic st, logic [3:0] rd, logic cv, logic [1:0] ow, logic bz);
        vec_t v;
        v.scen = scen; v.flush = fl; v.empty = emp; v.rs1 = r1; v.rs2 = r2; v.stall = st;
        v.expRd = rd; v.expCdb = cv; v.expOwner = ow; v.expBusy = bz;
        return v;
    endfunction

    function automatic int latOf(int u);
        case (u)
            0: return INT_LAT;
            1: return MEM_LAT;
            2: return MUL_LAT;
            default: return DIV_LAT;
        endcase
    endfunction

    function automatic logic [1:0] encodeSel(logic [3:0] rd);
        if (rd[1]) return 2'd1;
        if (rd[2]) return 2'd2;
        if (rd[3]) return 2'd3;
        return 2'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] rd, input logic cv,
                            input logic [1:0] ow, input logic bz);
        checkOutput({tag, " q_rd_en"}, qif.q_rd_en, rd);
        checkOutput({tag, " issue_valid"}, {3'b0, issue_valid}, {3'b0, |rd});
        checkOutput({tag, " issue_sel"}, {2'b0, issue_sel}, {2'b0, encodeSel(rd)});
        checkOutput({tag, " cdb_valid_slot"}, {3'b0, cdb_valid_slot}, {3'b0, cv});
        checkOutput({tag, " cdb_owner"}, {2'b0, cdb_owner}, {2'b0, ow});
        checkOutput({tag, " div_busy"}, {3'b0, div_busy}, {3'b0, bz});
    endtask

    task automatic modelReset();
        mClaim.delete();
        mCyc = 0;
        mRr = 0;
        mDivLast = -1000;
    endtask

    // Hold reset with every head ready, check the cleared outputs, then release idle.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        flush = 1'b0;
        mem_stall = 1'b0;
        qif.q_empty = 4'b0000;
        qif.q_rs1_valid = 4'b1111;
        qif.q_rs2_valid = 4'b1111;
        #1;
        checkAll("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        #2;
        qif.q_empty = 4'b1111;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic applyStimulus(input logic fl, input logic [3:0] emp, input logic [3:0] r1,
                                 input logic [3:0] r2, input logic st);
        @(negedge clk);
        flush = fl;
        qif.q_empty = emp;
        qif.q_rs1_valid = r1;
        qif.q_rs2_valid = r2;
        mem_stall = st;
        #1;
    endtask

    task automatic modelEval(output logic [3:0] rd, output logic cv, output logic [1:0] ow,
                             output logic bz, output int win);
        int i;
        win = -1;
        for (int off = 0; off < 4; off++) begin
            i = (mRr + off) % 4;
            if (win < 0 && !qif.q_empty[i] && qif.q_rs1_valid[i] && qif.q_rs2_valid[i]
                && !mClaim.exists(mCyc + latOf(i))
                && !(i == 1 && mem_stall)
                && !(i == 3 && mCyc < mDivLast + DIV_LAT)) begin
                win = i;
            end
        end
        if (flush) win = -1;
        rd = 4'b0000;
        if (win >= 0) rd[win] = 1'b1;
        cv = mClaim.exists(mCyc);
        ow = cv ? 2'(mClaim[mCyc]) : 2'd0;
        bz = (mCyc > mDivLast) && (mCyc <= mDivLast + DIV_LAT);
    endtask

    task automatic modelCommit(input int win);
        if (flush) begin
            mClaim.delete();
            mRr = 0;
            mDivLast = -1000;
        end else if (win >= 0) begin
            mClaim[mCyc + latOf(win)] = win;
            mRr = (win + 1) % 4;
            if (win == 3) mDivLast = mCyc;
        end
        mCyc++;
    endtask

    initial begin
        logic [3:0] eRd;
        logic       eCv;
        logic [1:0] eOw;
        logic       eBz;
        int         eWin;

        qif.q_empty = 4'b1111;
        qif.q_rs1_valid = 4'b0000;
        qif.q_rs2_valid = 4'b0000;

        // Scenario 0: all four heads ready for cycles 0-3.
        for (int c = 0; c < 4; c++)
            vecs.push_back(mk(0, 0, 4'b0000, 4'hF, 4'hF, 0, 4'b0001 << c, c == 1 || c == 3,
                              c == 3 ? 2'd1 : 2'd0, c == 3 ? 1'b0 : 1'b0));
        for (int c = 4; c < 13; c++)
            vecs.push_back(mk(0, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, c == 6 || c == 11,
                              c == 6 ? 2'd2 : (c == 11 ? 2'd3 : 2'd0), c <= 11));
        // Scenario 1: MUL at cycle 0 blocks INT at cycle 3.
        vecs.push_back(mk(1, 0, 4'b1011, 4'hF, 4'hF, 0, 4'b0100, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b1110, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b1110, 4'hF, 4'hF, 0, 4'b0001, 1, 2'd2, 0));
        vecs.push_back(mk(1, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 1, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        // Scenario 2: two DIV entries back to back.
        for (int c = 0; c < 18; c++)
            vecs.push_back(mk(2, 0, c <= 8 ? 4'b0111 : 4'b1111, 4'hF, 4'hF, 0,
                              (c == 0 || c == 8) ? 4'b1000 : 4'b0000,
                              c == 8 || c == 16, (c == 8 || c == 16) ? 2'd3 : 2'd0,
                              c >= 1 && c <= 16));
        // Scenario 3: mem_stall skips MEM, then MEM issues once the stall drops.
        vecs.push_back(mk(3, 0, 4'b1110, 4'hF, 4'hF, 0, 4'b0001, 0, 2'd0, 0));
        vecs.push_back(mk(3, 0, 4'b1100, 4'hF, 4'hF, 1, 4'b0001, 1, 2'd0, 0));
        vecs.push_back(mk(3, 0, 4'b1100, 4'hF, 4'hF, 0, 4'b0010, 1, 2'd0, 0));
        vecs.push_back(mk(3, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(3, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 1, 2'd1, 0));
        // Scenario 4: flush cancels the MUL reservation and resets the pointer.
        vecs.push_back(mk(4, 0, 4'b1011, 4'hF, 4'hF, 0, 4'b0100, 0, 2'd0, 0));
        vecs.push_back(mk(4, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(4, 1, 4'b1010, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(4, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(4, 0, 4'b0101, 4'hF, 4'hF, 0, 4'b0010, 0, 2'd0, 0));
        vecs.push_back(mk(4, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(4, 0, 4'b1111, 4'hF, 4'hF, 0, 4'b0000, 1, 2'd1, 0));
        // Scenario 5: a head needs both operands valid.
        vecs.push_back(mk(5, 0, 4'b0000, 4'hF, 4'h0, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(5, 0, 4'b0000, 4'h0, 4'hF, 0, 4'b0000, 0, 2'd0, 0));
        vecs.push_back(mk(5, 0, 4'b0000, 4'hF, 4'hF, 0, 4'b0001, 0, 2'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].scen != vecs[i-1].scen) doReset();
            applyStimulus(vecs[i].flush, vecs[i].empty, vecs[i].rs1, vecs[i].rs2, vecs[i].stall);
            checkAll($sformatf("scen%0d step%0d", vecs[i].scen, i), vecs[i].expRd,
                     vecs[i].expCdb, vecs[i].expOwner, vecs[i].expBusy);
        end

        // Randomized traffic against the calendar model.
        doReset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] emp;
            logic [3:0] r1;
            logic [3:0] r2;
            for (int b = 0; b < 4; b++) begin
                emp[b] = ($urandom_range(0, 99) < 35);
                r1[b]  = ($urandom_range(0, 99) < 80);
                r2[b]  = ($urandom_range(0, 99) < 80);
            end
            applyStimulus($urandom_range(0, 99) < 4, emp, r1, r2, $urandom_range(0, 99) < 25);
            modelEval(eRd, eCv, eOw, eBz, eWin);
            checkAll($sformatf("rand%0d", c), eRd, eCv, eOw, eBz);
            modelCommit(eWin);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
